// File: rtl/tt_div_pkg.sv
// ============================================================================
// Module   : tt_div_pkg
// Purpose  : Shared widths, state encoding and constants for the 8/4 divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_div_pkg;

    localparam int N_W = 8;
    localparam int D_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    localparam logic [D_W-1:0] ERR_FILL   = 4'hF;
    localparam logic [7:0]     UIO_OE_VAL = 8'b1110_0000;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import tt_div_pkg::*;
(
    input  logic [D_W:0]   p_in,
    input  logic           n_bit,
    input  logic [D_W-1:0] d,
    output logic [D_W:0]   p_out,
    output logic           q_bit
);

    logic [D_W:0] t;

    // The MSB of the partial remainder is always zero here because P < D
    // is maintained by the overflow check at accept time.
    logic unused_p_msb;
    assign unused_p_msb = p_in[D_W];

    assign t     = {p_in[D_W-1:0], n_bit};
    assign q_bit = (t >= {1'b0, d});
    assign p_out = q_bit ? (t - {1'b0, d}) : t;

endmodule

`default_nettype wire

// File: rtl/tt_um_seq_divider_hhrb98.sv
// ============================================================================
// Module   : tt_um_seq_divider_hhrb98
// Purpose  : Sequential 8-bit / 4-bit restoring divider tile with start/busy/
//            done handshake. Optional macro DIV_ENA_GATE_EN gates on ena.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_seq_divider_hhrb98
    import tt_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t         state, state_nxt;
    logic [1:0]     count, count_nxt;
    logic [D_W:0]   p, p_nxt;
    logic [3:0]     n_lo, n_lo_nxt;
    logic [D_W-1:0] d_lat, d_lat_nxt;
    logic [D_W-1:0] q_acc, q_acc_nxt;
    logic [7:0]     res, res_nxt;
    logic           busy, busy_nxt;
    logic           done, done_nxt;
    logic           err, err_nxt;

    logic           adv;
    logic           start;
    logic [D_W-1:0] d_in;
    logic [D_W:0]   step_p;
    logic           step_q;

    assign start = uio_in[4];
    assign d_in  = uio_in[3:0];

`ifdef DIV_ENA_GATE_EN
    assign adv = ena;
`else
    assign adv = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:5]};

    div_step u_step (
        .p_in  (p),
        .n_bit (n_lo[count]),
        .d     (d_lat),
        .p_out (step_p),
        .q_bit (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 2'd0;
            p     <= '0;
            n_lo  <= '0;
            d_lat <= '0;
            q_acc <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            p     <= p_nxt;
            n_lo  <= n_lo_nxt;
            d_lat <= d_lat_nxt;
            q_acc <= q_acc_nxt;
            res   <= res_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        p_nxt     = p;
        n_lo_nxt  = n_lo;
        d_lat_nxt = d_lat;
        q_acc_nxt = q_acc;
        res_nxt   = res;
        busy_nxt  = busy;
        done_nxt  = done;
        err_nxt   = err;

        case (state)
            IDLE, DONE: begin
                if (start && adv) begin
                    n_lo_nxt  = ui_in[3:0];
                    d_lat_nxt = d_in;
                    q_acc_nxt = '0;
                    // Requiring N[7:4] < D guarantees a 4-bit quotient.
                    if ((d_in == '0) || (ui_in[7:4] >= d_in)) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        res_nxt   = {ERR_FILL, ERR_FILL};
                    end else begin
                        state_nxt = RUN;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        err_nxt   = 1'b0;
                        res_nxt   = '0;
                        p_nxt     = {1'b0, ui_in[7:4]};
                        count_nxt = 2'd3;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    p_nxt            = step_p;
                    q_acc_nxt[count] = step_q;
                    if (count == 2'd0) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        res_nxt   = {step_p[D_W-1:0], q_acc_nxt};
                    end else begin
                        count_nxt = count - 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign uo_out  = res;
    assign uio_out = {err, done, busy, 5'b0_0000};
    assign uio_oe  = UIO_OE_VAL;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// ============================================================================
// Module   : tb_tt_um_seq_divider_hhrb98
// Purpose  : Self-checking bench for the sequential 8/4 divider tile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_seq_divider_hhrb98;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_seq_divider_hhrb98 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic       e;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];

    int vectors;
    int miscompares;

    wire busy = uio_out[5];
    wire done = uio_out[6];
    wire err  = uio_out[7];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_and_compare(input string tag, input int lat, input int exp_lat);
        vec_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, " uo_out"}, uo_out, {e.r, e.q});
            check({tag, " err"}, err, e.e);
            check({tag, " busy_at_done"}, busy, 0);
            if (exp_lat >= 0) check({tag, " latency"}, lat, exp_lat);
        end
    endtask

    // Drive one division with a single-cycle start and wait for done.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int busyc;
        @(negedge clk);
        ui_in  = v.n;
        uio_in = {3'b000, 1'b1, v.d};
        sb.push_back(v);
        @(posedge clk);
        #1;
        uio_in[4] = 1'b0;
        cyc   = 0;
        busyc = 0;
        while (!done && cyc < 20) begin
            if (busy) busyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            check({tag, " timeout"}, 0, 1);
            void'(sb.pop_front());
        end else begin
            check({tag, " busy_cycles"}, busyc, v.e ? 0 : 4);
            pop_and_compare(tag, cyc, v.e ? 0 : 4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        int lat;
        vectors     = 0;
        miscompares = 0;

        //           n      d     q     r     e
        tbl[0] = '{8'd200, 4'd13, 4'd15, 4'd5,  1'b0};
        tbl[1] = '{8'd143, 4'd11, 4'd13, 4'd0,  1'b0};
        tbl[2] = '{8'd0,   4'd5,  4'd0,  4'd0,  1'b0};
        tbl[3] = '{8'd77,  4'd0,  4'hF,  4'hF,  1'b1};
        tbl[4] = '{8'hF0,  4'd3,  4'hF,  4'hF,  1'b1};
        tbl[5] = '{8'h2F,  4'd3,  4'd15, 4'd2,  1'b0};
        tbl[6] = '{8'd120, 4'd9,  4'd13, 4'd3,  1'b0};
        tbl[7] = '{8'd1,   4'd1,  4'd1,  4'd0,  1'b0};
        tbl[8] = '{8'd17,  4'd2,  4'd8,  4'd1,  1'b0};
        tbl[9] = '{8'd255, 4'd15, 4'hF,  4'hF,  1'b1};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hE0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during the second RUN cycle.
        @(negedge clk);
        ui_in  = 8'd200;
        uio_in = {3'b000, 1'b1, 4'd13};
        @(posedge clk);
        #1;
        uio_in[4] = 1'b0;
        @(posedge clk);
        #1;
        check("midrun busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset uo_out", uo_out, 8'h00);
        check("midrun_reset uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset no_restart", uio_out, 8'h00);
        run_vec('{8'd100, 4'd7, 4'd14, 4'd2, 1'b0}, "after_reset");

        // Start held high across three operand sets; operands change mid-RUN.
        @(negedge clk);
        ui_in  = 8'd200;
        uio_in = {3'b000, 1'b1, 4'd13};
        sb.push_back('{8'd200, 4'd13, 4'd15, 4'd5, 1'b0});
        sb.push_back('{8'd143, 4'd11, 4'd13, 4'd0, 1'b0});
        sb.push_back('{8'h2F,  4'd3,  4'd15, 4'd2, 1'b0});
        c = 0;
        lat = 0;
        @(posedge clk);
        #1;
        while (sb.size() != 0 && c < 40) begin
            if (c == 1) begin ui_in = 8'd143; uio_in = {3'b000, 1'b1, 4'd11}; end
            if (c == 6) begin ui_in = 8'h2F;  uio_in = {3'b000, 1'b1, 4'd3};  end
            @(posedge clk);
            #1;
            c++;
            lat++;
            if (done) begin
                pop_and_compare($sformatf("b2b@%0d", c), lat, 4);
                lat = -1;
            end
        end
        check("b2b all_results", sb.size(), 0);
        uio_in[4] = 1'b0;
        sb.delete();

`ifdef DIV_ENA_GATE_EN
        // ena low for three cycles mid-RUN stretches latency to 7.
        @(negedge clk);
        ui_in  = 8'd200;
        uio_in = {3'b000, 1'b1, 4'd13};
        sb.push_back('{8'd200, 4'd13, 4'd15, 4'd5, 1'b0});
        @(posedge clk);
        #1;
        uio_in[4] = 1'b0;
        c = 0;
        while (!done && c < 20) begin
            if (c == 1) ena = 1'b0;
            if (c == 4) ena = 1'b1;
            @(posedge clk);
            #1;
            c++;
        end
        if (!done) check("ena_gate timeout", 0, 1);
        pop_and_compare("ena_gate", c, 7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
